sonic_sensor_responder: RTL and testbench

Single-wire ultrasonic ranging sensor emulator: the responder end of the trigger/echo protocol used by the team's ultrasonic distance-sensor controller. It watches the shared bidirectional `sig` line for a host trigger pulse, waits a fixed holdoff, then drives an echo pulse whose width in clock cycles equals a programmed distance value. It sits in test and hardware-in-the-loop builds in place of the physical sensor, so the controller and downstream logic can be exercised with known distances.

---
 rtl/sonic_sensor_responder_pkg.sv | 37 +++
 rtl/sonic_sensor_responder_sig_sync_edge.sv | 39 +++
 rtl/sonic_sensor_responder.sv | 174 +++++++++++++++++
 tb/tb_sonic_sensor_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_sensor_responder_pkg.sv
// Shared definitions for the ultrasonic sensor responder.
// Holds the responder state encoding, the default timing constants (also used
// by the distance-sensor controller bench) and the echo-length clamp helper.
package sonic_sensor_responder_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE    = 3'd0,
        STATE_TRIG    = 3'd1,
        STATE_HOLDOFF = 3'd2,
        STATE_ECHO    = 3'd3,
        STATE_RECOVER = 3'd4
    } state_t;

    // Default timing in clock cycles (100 MHz system clock).
    localparam int unsigned DEF_MIN_TRIG = 32'd200;
    localparam int unsigned DEF_MAX_TRIG = 32'd1000;
    localparam int unsigned DEF_HOLDOFF  = 32'd60000;
    localparam int unsigned DEF_ECHO_MIN = 32'd11500;
    localparam int unsigned DEF_ECHO_MAX = 32'd1850000;
    localparam int unsigned DEF_RECOVER  = 32'd20000;

    // Limit a requested echo length to the [lo, hi] window.
    function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
        logic [31:0] res;
        if (len < lo) begin
            res = lo;
        end else if (len > hi) begin
            res = hi;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/sonic_sensor_responder_sig_sync_edge.sv
// Two-flop synchronizer for the asynchronous sensor line, followed by an
// edge detector.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   din       : raw asynchronous input
//   level     : synchronized level
//   rise/fall : one-cycle pulses in the first cycle the synchronized level
//               is seen high / low
module sig_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;
    assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/sonic_sensor_responder.sv
// Ultrasonic ranging sensor emulator (responder side of trigger/echo).
// Watches the shared line for a host trigger pulse, waits a fixed holdoff,
// then drives an echo pulse whose width in cycles is the clamped echo_len.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   enable      : gates acceptance of new triggers (sensor present)
//   echo_len    : echo width in cycles, sampled when a trigger is accepted
//   sig         : shared sensor line; driven 1 during echo, otherwise Z
//   busy        : high while a transaction is in progress
//   echo_active : registered line drive enable
//   trig_err    : one-cycle pulse for each rejected trigger
//   trig_count  : wrapping count of accepted triggers
module sonic_sensor_responder
    import sonic_sensor_responder_pkg::*;
#(
    parameter int unsigned MIN_TRIG = DEF_MIN_TRIG,
    parameter int unsigned MAX_TRIG = DEF_MAX_TRIG,
    parameter int unsigned HOLDOFF  = DEF_HOLDOFF,
    parameter int unsigned ECHO_MIN = DEF_ECHO_MIN,
    parameter int unsigned ECHO_MAX = DEF_ECHO_MAX,
    parameter int unsigned RECOVER  = DEF_RECOVER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] echo_len,
    inout  wire         sig,
    output logic        busy,
    output logic        echo_active,
    output logic        trig_err,
    output logic [15:0] trig_count
);

    logic   sig_s;
    logic   rise_s;
    logic   fall_s;

    state_t      state_r, state_s;
    logic [31:0] cnt_r, cnt_s;
    logic [31:0] len_r, len_s;
    logic        drive_r, drive_s;
    logic        err_s;
    logic        accept_s;
    logic        busy_r;
    logic        err_r;
    logic [15:0] count_r;

    sig_sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sig),
        .level (sig_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Next-state, shared counter, latched length and line drive.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        len_s    = len_r;
        drive_s  = drive_r;
        err_s    = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            STATE_IDLE: begin
                drive_s = 1'b0;
                if (rise_s && enable) begin
                    state_s = STATE_TRIG;
                    cnt_s   = 32'd1;
                end else begin
                    cnt_s   = 32'd0;
                end
            end
            STATE_TRIG: begin
                if (fall_s) begin
                    if (cnt_r < MIN_TRIG) begin
                        err_s   = 1'b1;
                        state_s = STATE_IDLE;
                    end else begin
                        accept_s = 1'b1;
                        len_s    = clamp_len(echo_len, ECHO_MIN, ECHO_MAX);
                        state_s  = STATE_HOLDOFF;
                    end
                    cnt_s = 32'd0;
                end else if (sig_s) begin
                    // cnt_r already holds MAX_TRIG high cycles: this one is too many.
                    if (cnt_r >= MAX_TRIG) begin
                        err_s   = 1'b1;
                        state_s = STATE_RECOVER;
                        cnt_s   = 32'd0;
                    end else begin
                        cnt_s   = cnt_r + 32'd1;
                    end
                end else begin
                    // Line low without a falling edge cannot occur; resync to idle.
                    state_s = STATE_IDLE;
                    cnt_s   = 32'd0;
                end
            end
            STATE_HOLDOFF: begin
                if (cnt_r >= HOLDOFF - 32'd1) begin
                    state_s = STATE_ECHO;
                    cnt_s   = 32'd0;
                    drive_s = 1'b1;
                end else begin
                    cnt_s   = cnt_r + 32'd1;
                end
            end
            STATE_ECHO: begin
                if (cnt_r >= len_r - 32'd1) begin
                    state_s = STATE_RECOVER;
                    cnt_s   = 32'd0;
                    drive_s = 1'b0;
                end else begin
                    cnt_s   = cnt_r + 32'd1;
                end
            end
            STATE_RECOVER: begin
                drive_s = 1'b0;
                if (cnt_r >= RECOVER - 32'd1) begin
                    state_s = STATE_IDLE;
                    cnt_s   = 32'd0;
                end else begin
                    cnt_s   = cnt_r + 32'd1;
                end
            end
            default: begin
                state_s = STATE_IDLE;
                cnt_s   = 32'd0;
                drive_s = 1'b0;
            end
        endcase
    end

    // State, counter, latched length and line drive registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= STATE_IDLE;
            cnt_r   <= 32'd0;
            len_r   <= 32'd0;
            drive_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            len_r   <= len_s;
            drive_r <= drive_s;
        end
    end

    // Registered status outputs and accepted-trigger statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            count_r <= 16'd0;
        end else begin
            busy_r <= (state_s != STATE_IDLE);
            err_r  <= err_s;
            if (accept_s) begin
                count_r <= count_r + 16'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign sig         = drive_r ? 1'b1 : 1'bz;
    assign echo_active = drive_r;
    assign busy        = busy_r;
    assign trig_err    = err_r;
    assign trig_count  = count_r;

endmodule

// File: tb/tb_sonic_sensor_responder.sv
// Self-checking bench for sonic_sensor_responder, run with shortened timing
// parameters so that every transaction completes in a few hundred cycles.
module tb_sonic_sensor_responder;

    localparam int unsigned P_MIN  = 20;
    localparam int unsigned P_MAX  = 100;
    localparam int unsigned P_HOLD = 60;
    localparam int unsigned P_EMIN = 30;
    localparam int unsigned P_EMAX = 200;
    localparam int unsigned P_REC  = 40;
    localparam int unsigned LIMIT  = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] echo_len;
    logic        host_hi;
    wire         sig;
    logic        busy;
    logic        echo_active;
    logic        trig_err;
    logic [15:0] trig_count;

    assign sig = host_hi ? 1'b1 : 1'bz;
    pulldown (sig);

    sonic_sensor_responder #(
        .MIN_TRIG (P_MIN),
        .MAX_TRIG (P_MAX),
        .HOLDOFF  (P_HOLD),
        .ECHO_MIN (P_EMIN),
        .ECHO_MAX (P_EMAX),
        .RECOVER  (P_REC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .echo_len    (echo_len),
        .sig         (sig),
        .busy        (busy),
        .echo_active (echo_active),
        .trig_err    (trig_err),
        .trig_count  (trig_count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned model_count = 0;

    // Free-running cycle index and negedge-sampled line monitor.
    int unsigned cyc = 0;
    int unsigned echo_cycles = 0;
    int unsigned err_pulses = 0;
    int unsigned rises = 0;
    int unsigned rise_cyc = 0;
    int unsigned contention = 0;
    logic        prev_act = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_act <= echo_active;
        if (echo_active) echo_cycles <= echo_cycles + 1;
        if (trig_err) err_pulses <= err_pulses + 1;
        if (echo_active && !prev_act) begin
            rises    <= rises + 1;
            rise_cyc <= cyc;
        end
        if (sig !== (echo_active | host_hi)) contention <= contention + 1;
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int unsigned model_len(input logic [31:0] l);
        if (l < P_EMIN) return P_EMIN;
        if (l > P_EMAX) return P_EMAX;
        return l;
    endfunction

    task automatic wait_idle(input string tag);
        int waited = 0;
        while (busy && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_echo(input logic level, input string tag);
        int waited = 0;
        while (echo_active !== level && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_echo_wait"}, echo_active, level);
    endtask

    // One trigger transaction with full outcome checks.
    task automatic run_trig(input int unsigned width, input logic [31:0] len, input logic en,
                            input bit exp_acc, input bit exp_err, input int unsigned exp_echo,
                            input string tag);
        int unsigned e0, r0, n0, fall_cyc;
        logic b2, b3;
        @(negedge clk);
        enable   = en;
        echo_len = len;
        e0 = echo_cycles;
        r0 = err_pulses;
        n0 = rises;
        host_hi = 1'b1;
        repeat (width) @(negedge clk);
        host_hi  = 1'b0;
        fall_cyc = cyc;
        repeat (2) @(negedge clk);
        b2 = busy;
        @(negedge clk);
        b3 = busy;
        if (width <= P_MAX) begin
            check({tag, "_busy_f2"}, b2, en);
            check({tag, "_busy_f3"}, b3, en && exp_acc);
        end
        @(negedge clk);
        wait_idle(tag);
        repeat (3) @(negedge clk);
        if (exp_acc) model_count++;
        check({tag, "_echo_len"}, echo_cycles - e0, exp_echo);
        check({tag, "_err"}, err_pulses - r0, exp_err ? 1 : 0);
        check({tag, "_rises"}, rises - n0, exp_acc ? 1 : 0);
        check({tag, "_count"}, trig_count, 16'(model_count));
        if (exp_acc) check({tag, "_delay"}, rise_cyc - fall_cyc - 1, P_HOLD + 2);
    endtask

    typedef struct {
        int unsigned width;
        logic [31:0] len;
        logic        en;
        bit          acc;
        bit          err;
        int unsigned echo;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int unsigned n0, e0, w;
        logic [31:0] l;
        logic        en;
        bit          acc;

        tbl[0]  = '{50, 32'd100, 1'b1, 1'b1, 1'b0, 100};
        tbl[1]  = '{15, 32'd100, 1'b1, 1'b0, 1'b1, 0};
        tbl[2]  = '{20, 32'd80, 1'b1, 1'b1, 1'b0, 80};
        tbl[3]  = '{19, 32'd80, 1'b1, 1'b0, 1'b1, 0};
        tbl[4]  = '{100, 32'd80, 1'b1, 1'b1, 1'b0, 80};
        tbl[5]  = '{101, 32'd80, 1'b1, 1'b0, 1'b1, 0};
        tbl[6]  = '{50, 32'd5, 1'b1, 1'b1, 1'b0, 30};
        tbl[7]  = '{50, 32'd3000, 1'b1, 1'b1, 1'b0, 200};
        tbl[8]  = '{50, 32'd29, 1'b1, 1'b1, 1'b0, 30};
        tbl[9]  = '{50, 32'd201, 1'b1, 1'b1, 1'b0, 200};
        tbl[10] = '{50, 32'd30, 1'b1, 1'b1, 1'b0, 30};
        tbl[11] = '{50, 32'd100, 1'b0, 1'b0, 1'b0, 0};
        tbl[12] = '{50, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 200};

        rst = 1'b1; enable = 1'b0; echo_len = 32'd0; host_hi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_echo_active", echo_active, 0);
        check("rst_trig_err", trig_err, 0);
        check("rst_trig_count", trig_count, 0);
        check("rst_sig", sig, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        foreach (tbl[i]) begin
            run_trig(tbl[i].width, tbl[i].len, tbl[i].en, tbl[i].acc, tbl[i].err,
                     tbl[i].echo, $sformatf("tbl%0d", i));
        end

        // Second trigger during RECOVER must be ignored.
        @(negedge clk);
        enable = 1'b1; echo_len = 32'd50;
        n0 = rises; e0 = echo_cycles;
        host_hi = 1'b1; repeat (40) @(negedge clk); host_hi = 1'b0;
        wait_echo(1'b1, "rec_a");
        wait_echo(1'b0, "rec_b");
        repeat (5) @(negedge clk);
        host_hi = 1'b1; repeat (25) @(negedge clk); host_hi = 1'b0;
        wait_idle("rec");
        repeat (P_HOLD + P_REC) @(negedge clk);
        model_count++;
        check("rec_rises", rises - n0, 1);
        check("rec_echo_len", echo_cycles - e0, 50);
        check("rec_count", trig_count, 16'(model_count));
        check("rec_busy", busy, 0);

        // Dropping enable mid-transaction does not abort it.
        @(negedge clk);
        enable = 1'b1; echo_len = 32'd70;
        e0 = echo_cycles;
        host_hi = 1'b1; repeat (30) @(negedge clk); host_hi = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_idle("endrop");
        model_count++;
        check("endrop_echo_len", echo_cycles - e0, 70);
        check("endrop_count", trig_count, 16'(model_count));

        // Reset in the middle of an echo.
        @(negedge clk);
        enable = 1'b1; echo_len = 32'd150;
        host_hi = 1'b1; repeat (30) @(negedge clk); host_hi = 1'b0;
        wait_echo(1'b1, "mid");
        repeat (20) @(negedge clk);
        check("mid_active", echo_active, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sig", sig, 0);
        check("midrst_echo_active", echo_active, 0);
        check("midrst_busy", busy, 0);
        check("midrst_trig_err", trig_err, 0);
        check("midrst_trig_count", trig_count, 0);
        rst = 1'b0;
        model_count = 0;
        repeat (3) @(negedge clk);
        run_trig(40, 32'd60, 1'b1, 1'b1, 1'b0, 60, "post_rst");

        // Randomized transactions against the behavioural model.
        for (int k = 0; k < 40; k++) begin
            w   = $urandom_range(P_MAX + 10, P_MIN - 10);
            l   = $urandom_range(P_EMAX + 60, 0);
            en  = ($urandom_range(9, 0) != 0);
            acc = en && (w >= P_MIN) && (w <= P_MAX);
            run_trig(w, l, en, acc, en && !acc, acc ? model_len(l) : 0,
                     $sformatf("rnd%0d", k));
        end

        check("no_contention", contention, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
